// File: rtl/lcd1602_receiver.sv
// lcd1602_receiver: write-only HD44780-style bus slave mirroring a 2x16 DDRAM.
// Define LCD1602_RECEIVER_CGRAM_EN to implement the readable 64x5 CGRAM.
module lcd1602_receiver #(
   parameter int SYNC_STAGES  = 2,
   parameter int CLEAR_CYCLES = 32
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       rs,
   input  logic       rw,
   input  logic       enable,
   input  logic [7:0] data,
   input  logic [4:0] rd_addr,
   output logic [7:0] rd_char,
   input  logic [5:0] cg_rd_addr,
   output logic [4:0] cg_rd_data,
   output logic [6:0] cursor_addr,
   output logic       disp_on,
   output logic       cursor_on,
   output logic       blink_on,
   output logic       two_line,
   output logic       mode_8bit,
   output logic       busy,
   output logic       overrun_err,
   output logic       protocol_err
);
   localparam int CNT_W = (CLEAR_CYCLES > 32) ? $clog2(CLEAR_CYCLES) : 5;
   typedef enum logic [1:0] {IDLE, FILL, DONE} state_t;

   logic [SYNC_STAGES-1:0][10:0] sync_q, sync_d;
   logic [10:0]      sync_out;
   logic             en_prev_q, en_prev_d;
   logic             txn_vld_q, txn_vld_d, txn_rs_q, txn_rs_d, txn_rw_q, txn_rw_d;
   logic [7:0]       txn_data_q, txn_data_d;
   state_t           state_q, state_d;
   logic [CNT_W-1:0] fill_cnt_q, fill_cnt_d;
   logic [6:0]       ac_q, ac_d;
   logic [5:0]       cga_q, cga_d;
   logic             id_q, id_d, sel_cg_q, sel_cg_d;
   logic             disp_q, disp_d, cur_q, cur_d, blink_q, blink_d;
   logic             two_q, two_d, m8_q, m8_d, ovr_q, ovr_d, prot_q, prot_d;
   logic [7:0]       rd_char_q, rd_char_d;
   logic [7:0]       ddram_q [32];
   logic             dd_we, cg_we;
   logic [4:0]       dd_waddr, cg_wdata;
   logic [7:0]       dd_wdata;
   logic [5:0]       cg_waddr;

   // DDRAM address ring: line 0 is 0x00-0x0F, line 1 is 0x40-0x4F
   function automatic logic [6:0] ac_step(input logic [6:0] a, input logic up);
      logic [6:0] r;
      if (up) r = (a == 7'h0F) ? 7'h40 : (a == 7'h4F) ? 7'h00 : a + 7'd1;
      else    r = (a == 7'h00) ? 7'h4F : (a == 7'h40) ? 7'h0F : a - 7'd1;
      return r;
   endfunction

   assign sync_out = sync_q[SYNC_STAGES-1];
   assign busy     = (state_q != IDLE);

   always_comb begin
      sync_d     = {sync_q[SYNC_STAGES-2:0], {rs, rw, enable, data}};
      en_prev_d  = sync_out[8];
      txn_vld_d  = en_prev_q & ~sync_out[8];
      txn_rs_d   = sync_out[10];
      txn_rw_d   = sync_out[9];
      txn_data_d = sync_out[7:0];
      rd_char_d  = ddram_q[rd_addr];
   end

   always_comb begin
      state_d = state_q;   fill_cnt_d = fill_cnt_q;
      ac_d = ac_q;         cga_d = cga_q;       id_d = id_q;     sel_cg_d = sel_cg_q;
      disp_d = disp_q;     cur_d = cur_q;       blink_d = blink_q;
      two_d = two_q;       m8_d = m8_q;         ovr_d = ovr_q;   prot_d = prot_q;
      dd_we = 1'b0;        dd_waddr = {ac_q[6], ac_q[3:0]};   dd_wdata = txn_data_q;
      cg_we = 1'b0;        cg_waddr = cga_q;    cg_wdata = txn_data_q[4:0];
      case (state_q)
         FILL: begin
            dd_we      = 1'b1;
            dd_waddr   = fill_cnt_q[4:0];
            dd_wdata   = 8'h20;
            fill_cnt_d = fill_cnt_q + CNT_W'(1);
            if (fill_cnt_q == CNT_W'(CLEAR_CYCLES - 1)) state_d = DONE;
         end
         DONE: begin
            ac_d = 7'h00; id_d = 1'b1; sel_cg_d = 1'b0; state_d = IDLE;
         end
         default: ;
      endcase
      if (txn_vld_q) begin
         if (busy) ovr_d = 1'b1;
         else if (txn_rw_q) prot_d = 1'b1;
         else if (txn_rs_q) begin
            if (sel_cg_q) begin
               cg_we = 1'b1;
               cga_d = id_q ? cga_q + 6'd1 : cga_q - 6'd1;
            end else begin
               dd_we = 1'b1;
               ac_d  = ac_step(ac_q, id_q);
            end
         end else begin
            casez (txn_data_q)
               8'b1???????: begin
                  // only 0x00-0x0F and 0x40-0x4F map onto the 2x16 window
                  if (txn_data_q[5:4] == 2'b00) begin
                     ac_d = txn_data_q[6:0]; sel_cg_d = 1'b0;
                  end else prot_d = 1'b1;
               end
               8'b01??????: begin cga_d = txn_data_q[5:0]; sel_cg_d = 1'b1; end
               8'b001?????: begin m8_d = txn_data_q[4]; two_d = txn_data_q[3]; end
               8'b0001????: ac_d = ac_step(ac_q, txn_data_q[2]);
               8'b00001???: begin
                  disp_d = txn_data_q[2]; cur_d = txn_data_q[1]; blink_d = txn_data_q[0];
               end
               8'b000001??: id_d = txn_data_q[1];
               8'b0000001?: ac_d = 7'h00;
               8'b00000001: begin state_d = FILL; fill_cnt_d = '0; end
               default: ;
            endcase
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync_q <= '0;     en_prev_q <= 1'b0;
         txn_vld_q <= 1'b0; txn_rs_q <= 1'b0; txn_rw_q <= 1'b0; txn_data_q <= '0;
         state_q <= FILL;  fill_cnt_q <= '0;
         ac_q <= '0;       cga_q <= '0;       id_q <= 1'b1;    sel_cg_q <= 1'b0;
         disp_q <= 1'b0;   cur_q <= 1'b0;     blink_q <= 1'b0;
         two_q <= 1'b0;    m8_q <= 1'b1;      ovr_q <= 1'b0;   prot_q <= 1'b0;
         rd_char_q <= '0;
      end else begin
         sync_q <= sync_d; en_prev_q <= en_prev_d;
         txn_vld_q <= txn_vld_d; txn_rs_q <= txn_rs_d; txn_rw_q <= txn_rw_d;
         txn_data_q <= txn_data_d;
         state_q <= state_d; fill_cnt_q <= fill_cnt_d;
         ac_q <= ac_d;     cga_q <= cga_d;    id_q <= id_d;    sel_cg_q <= sel_cg_d;
         disp_q <= disp_d; cur_q <= cur_d;    blink_q <= blink_d;
         two_q <= two_d;   m8_q <= m8_d;      ovr_q <= ovr_d;  prot_q <= prot_d;
         rd_char_q <= rd_char_d;
      end
   end

   always_ff @(posedge clk) begin
      if (dd_we) ddram_q[dd_waddr] <= dd_wdata;
   end

`ifdef LCD1602_RECEIVER_CGRAM_EN
   logic [4:0] cgram_q [64];
   logic [4:0] cg_rd_data_q, cg_rd_data_d;

   assign cg_rd_data_d = cgram_q[cg_rd_addr];

   always_ff @(posedge clk) begin
      if (cg_we) cgram_q[cg_waddr] <= cg_wdata;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) cg_rd_data_q <= '0;
      else       cg_rd_data_q <= cg_rd_data_d;
   end

   assign cg_rd_data = cg_rd_data_q;
`else
   logic unused_cg;
   assign unused_cg  = ^{cg_we, cg_waddr, cg_wdata, cg_rd_addr};
   assign cg_rd_data = '0;
`endif

   assign rd_char      = rd_char_q;
   assign cursor_addr  = ac_q;
   assign disp_on      = disp_q;
   assign cursor_on    = cur_q;
   assign blink_on     = blink_q;
   assign two_line     = two_q;
   assign mode_8bit    = m8_q;
   assign overrun_err  = ovr_q;
   assign protocol_err = prot_q;
endmodule

// File: doc/lcd1602_receiver.md
LCD1602_RECEIVER -- requirements
Module: lcd1602_receiver

Interface
REQ-001 Parameter SYNC_STAGES, default 2, sets the synchronizer depth applied to rs, rw, enable and data (minimum 2).
REQ-002 Parameter CLEAR_CYCLES, default 32, sets the clk cycles taken to fill DDRAM with 0x20 during a clear.
REQ-003 Port clk, input, 1 bit: single system clock; all state updates on its rising edge.
REQ-004 Port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 Ports rs, rw and enable, inputs, 1 bit each: LCD bus register select, read/write and strobe, asynchronous to clk.
REQ-006 Port data, input, 8 bits: LCD bus data, sampled on the falling edge of enable.
REQ-007 Port rd_addr, input, 5 bits: display read index {line, col[3:0]}.
REQ-008 Port rd_char, output, 8 bits: DDRAM byte at rd_addr, registered with 1-cycle latency.
REQ-009 Port cg_rd_addr, input, 6 bits: CGRAM read index {char[2:0], row[2:0]}.
REQ-010 Port cg_rd_data, output, 5 bits: CGRAM row at cg_rd_addr, registered with 1-cycle latency.
REQ-011 Port cursor_addr, output, 7 bits: current DDRAM address counter (AC).
REQ-012 Ports disp_on, cursor_on, blink_on, two_line and mode_8bit, outputs, 1 bit each: latched control flags.
REQ-013 Port busy, output, 1 bit: a clear or reset-fill is in progress.
REQ-014 Ports overrun_err and protocol_err, outputs, 1 bit each: sticky error flags.

Function
REQ-015 Each of rs, rw, enable and data passes through a SYNC_STAGES flop chain; a falling edge is detected at the enable chain output, and rs/rw/data are taken from the same pipeline stage.
REQ-016 A detected falling edge commits one transaction, and its effect is visible on the outputs SYNC_STAGES+2 clk cycles after enable falls.
REQ-017 rw=1 transactions have no side effect other than setting protocol_err (bus reads are unsupported).
REQ-018 rs=0 decodes by the highest set bit: 0x01 clear; 0x02/0x03 AC=0x00; 0x04-0x07 latch I/D=data[1] (S ignored); 0x08-0x0F set disp_on/cursor_on/blink_on from data[2:0]; 0x10-0x1F move AC by ±1 per data[2] using the REQ-021 wrap; 0x20-0x3F mode_8bit=data[4], two_line=data[3]; 0x40-0x7F select CGRAM with CGA=data[5:0]; 0x80-0xFF select DDRAM with AC=data[6:0].
REQ-019 A set-DDRAM command with data[6:0] in 0x10-0x3F or 0x50-0x7F is ignored (AC and RAM selection unchanged) and sets protocol_err.
REQ-020 rs=1 writes data to the selected RAM at AC (DDRAM) or CGA (CGRAM, data[4:0]), then steps the address by +1 if I/D=1, else -1.
REQ-021 DDRAM stepping: +1 goes 0x0F->0x40 and 0x4F->0x00; -1 goes 0x00->0x4F and 0x40->0x0F. CGA wraps modulo 64.
REQ-022 The clear FSM has states IDLE, FILL and DONE. IDLE->FILL on the clear command; FILL writes 0x20 over CLEAR_CYCLES cycles (one DDRAM index per cycle); FILL->DONE; DONE sets AC=0x00, I/D=1, selects DDRAM, and returns to IDLE.
REQ-023 busy is 1 in FILL and DONE.
REQ-024 Any transaction committed while busy=1 is dropped and sets overrun_err.
REQ-025 A read index whose rd_addr falls outside 0-31 is impossible by width; rd_char is valid in all states, including while busy (it shows partial fill).

Reset
REQ-026 On reset assertion: disp_on=0, cursor_on=0, blink_on=0, two_line=0, mode_8bit=1, I/D=1, AC=0, CGA=0, DDRAM selected, both error flags 0, sync chains cleared to 0, rd_char=0, cg_rd_data=0.
REQ-027 On reset deassertion the FSM enters FILL, so busy=1 for CLEAR_CYCLES+1 cycles.
REQ-028 Reset asserted mid-FILL or mid-transaction aborts it; the sequence restarts from REQ-027 on release.
REQ-029 Error flags clear only on reset.

Configuration
REQ-030 Macro LCD1602_RECEIVER_CGRAM_EN: when defined, a 64x5 CGRAM is implemented and is readable via cg_rd_addr.
REQ-031 When LCD1602_RECEIVER_CGRAM_EN is undefined, CGRAM commands and writes still update CGA but the data is discarded, and cg_rd_data is constant 0.

Verification
REQ-032 Release reset and wait CLEAR_CYCLES+1 cycles -> busy falls; rd_char=0x20 for all 32 rd_addr values.
REQ-033 Send commands 0x38, 0x06, 0x0C, 0x01 -> mode_8bit=1, two_line=1, disp_on=1, cursor_on=0; busy high for 33 cycles after the clear commits.
REQ-034 Send 0x84 then data 'F','O','O','D' -> rd_addr 4..7 read 0x46, 0x4F, 0x4F, 0x44; cursor_addr=0x08.
REQ-035 Send 0x8F then 'A','B' -> 'A' at index 15, 'B' at index 16, cursor_addr=0x41. Send 0xCF then 'X','Y' -> 'Y' at index 0, cursor_addr=0x01.
REQ-036 Send data during busy -> RAM unchanged and overrun_err=1. Send command 0x90 -> AC unchanged and protocol_err=1. A transaction with rw=1 -> protocol_err=1.
REQ-037 Send 0x40 then eight writes of 0x1F -> with the macro defined, cg_rd_data=0x1F for cg_rd_addr 0-7; without it, cg_rd_data=0.
